// File: rtl/wide_add_seq_if.sv
// Stream bundle for wide_add_seq: operand word pairs in, registered sum words out.
// The in_sub field exists only when WIDE_ADD_SEQ_SUB_EN is defined.
interface wide_add_seq_if #(parameter int W = 32);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_last;
`ifdef WIDE_ADD_SEQ_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_carry;
    logic         out_err;

`ifdef WIDE_ADD_SEQ_SUB_EN
    modport slave (input in_valid, in_a, in_b, in_last, in_sub, out_ready,
                   output in_ready, out_valid, out_sum, out_last, out_carry, out_err);
    modport master (output in_valid, in_a, in_b, in_last, in_sub, out_ready,
                    input in_ready, out_valid, out_sum, out_last, out_carry, out_err);
`else
    modport slave (input in_valid, in_a, in_b, in_last, out_ready,
                   output in_ready, out_valid, out_sum, out_last, out_carry, out_err);
    modport master (output in_valid, in_a, in_b, in_last, out_ready,
                    input in_ready, out_valid, out_sum, out_last, out_carry, out_err);
`endif
endinterface

// File: rtl/wide_add_seq.sv
// Multi-word add sequencer around an external cla32, chaining carry word to word.
// Optional WIDE_ADD_SEQ_SUB_EN adds in_sub for two's-complement subtraction (A-B).

// state | meaning
// IDLE  | no operand in progress, next accepted word is a first word
// CHAIN | mid-operand, carry_q holds previous word's carry-out
module wide_add_seq #(
    parameter int W         = 32,
    parameter int MAX_WORDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    wide_add_seq_if.slave bus,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_sum,
    input  logic         add_cout
);
    localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [CW-1:0] WLAST = CW'(MAX_WORDS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CHAIN = 1'b1;

    logic [0:0]    state;
    logic          carry_q;
    logic [CW-1:0] wcnt;
    logic          accept;
    logic          at_limit;
    logic          final_word;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign at_limit     = (wcnt == WLAST);
    assign final_word   = bus.in_last || at_limit;

    assign add_a = bus.in_a;

`ifdef WIDE_ADD_SEQ_SUB_EN
    logic sub_q;
    logic sub_eff;

    // Operation is latched on the first word; later words' in_sub is ignored.
    assign sub_eff = (state == IDLE) ? bus.in_sub : sub_q;
    assign add_b   = sub_eff ? ~bus.in_b : bus.in_b;
    assign add_cin = (state == IDLE) ? sub_eff : carry_q;

    always_ff @(posedge clk) begin
        if (rst)
            sub_q <= 1'b0;
        else if (accept && state == IDLE)
            sub_q <= bus.in_sub;
    end
`else
    assign add_b   = bus.in_b;
    assign add_cin = (state == CHAIN) && carry_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            carry_q       <= 1'b0;
            wcnt          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_carry <= 1'b0;
            bus.out_err   <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= add_sum;
            bus.out_last  <= final_word;
            bus.out_carry <= add_cout;
            bus.out_err   <= at_limit && !bus.in_last;
            if (final_word) begin
                state   <= IDLE;
                carry_q <= 1'b0;
                wcnt    <= '0;
            end else begin
                state   <= CHAIN;
                carry_q <= add_cout;
                wcnt    <= wcnt + 1'b1;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed scenarios plus randomized streams checked against
// a whole-operand arithmetic model; cla32 is modelled behaviourally.
module tb_wide_add_seq;
    localparam int W  = 32;
    localparam int MW = 2;
    localparam int WD = W * MW + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
        logic         sub;
    } in_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         last;
        logic         carry;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    int           vectors = 0;
    int           miscompares = 0;
    in_t          stim_q[$];
    exp_t         exp_q[$];

    wide_add_seq_if #(.W(W)) bus();

    wide_add_seq #(.W(W), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

`ifdef WIDE_ADD_SEQ_SUB_EN
    logic sub_drv = 1'b0;
    assign bus.in_sub = sub_drv;
`endif

    wire [W+3:0] obs = {bus.out_valid, bus.out_last, bus.out_carry, bus.out_err, bus.out_sum};

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
    endtask

    // Splits the word stream into operands and computes each as one wide sum/difference.
    function automatic void build_expected();
        int start = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            int n = i - start + 1;
            if (stim_q[i].last || n == MW) begin
                logic [WD-1:0] av = '0, bv = '0, r, mask;
                logic          s = stim_q[start].sub;
                for (int k = 0; k < n; k++) begin
                    av[W*k +: W] = stim_q[start+k].a;
                    bv[W*k +: W] = stim_q[start+k].b;
                end
                mask = {WD{1'b1}} >> (WD - W * n);
                r = av + (s ? (~bv & mask) : bv) + {{(WD-1){1'b0}}, s};
                for (int k = 0; k < n; k++) begin
                    exp_t e;
                    e.sum   = r[W*k +: W];
                    e.last  = (k == n - 1);
                    e.carry = r[W*n];
                    e.err   = (k == n - 1) && !stim_q[i].last;
                    exp_q.push_back(e);
                end
                start = i + 1;
            end
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        put(1'b0, '0, '0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got %h want 0", obs);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        put(1'b1, 32'd43, 32'd45, 1'b1);
        cyc();
        vectors++;
        if (obs !== {4'b1100, 32'd88}) begin
            miscompares++;
            $display("FAIL single 43+45: got %h want %h", obs, {4'b1100, 32'd88});
        end
        put(1'b0, '0, '0, 1'b0);
        cyc();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single pop: got out_valid %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_chain();
        bus.out_ready = 1'b1;
        put(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        cyc();
        vectors++;
        if (obs !== {4'b1010, 32'h0}) begin
            miscompares++;
            $display("FAIL chain1 word0: got %h want %h", obs, {4'b1010, 32'h0});
        end
        put(1'b1, 32'd1, 32'd0, 1'b1);
        cyc();
        vectors++;
        if (obs !== {4'b1100, 32'h2}) begin
            miscompares++;
            $display("FAIL chain1 word1: got %h want %h", obs, {4'b1100, 32'h2});
        end
        put(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        cyc();
        vectors++;
        if (obs !== {4'b1010, 32'hFFFF_FFFE}) begin
            miscompares++;
            $display("FAIL chain2 word0: got %h want %h", obs, {4'b1010, 32'hFFFF_FFFE});
        end
        put(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        cyc();
        vectors++;
        if (obs !== {4'b1110, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL chain2 word1: got %h want %h", obs, {4'b1110, 32'hFFFF_FFFF});
        end
        put(1'b0, '0, '0, 1'b0);
        cyc();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        put(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        cyc();
        put(1'b1, 32'd1, 32'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || obs !== {4'b1010, 32'hFFFF_FFFE}) begin
                miscompares++;
                $display("FAIL stall cycle %0d: got in_ready %b out %h want 0 %h",
                         i, bus.in_ready, obs, {4'b1010, 32'hFFFF_FFFE});
            end
            cyc();
        end
        bus.out_ready = 1'b1;
        cyc();
        vectors++;
        if (obs !== {4'b1100, 32'd4}) begin
            miscompares++;
            $display("FAIL stall release word1: got %h want %h", obs, {4'b1100, 32'd4});
        end
        put(1'b0, '0, '0, 1'b0);
        cyc();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall duplicate: got out_valid %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_truncation();
        bus.out_ready = 1'b1;
        put(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        cyc();
        put(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        cyc();
        vectors++;
        if (obs !== {4'b1111, 32'h0}) begin
            miscompares++;
            $display("FAIL trunc forced last: got %h want %h", obs, {4'b1111, 32'h0});
        end
        put(1'b1, 32'd5, 32'd6, 1'b0);
        cyc();
        vectors++;
        if (obs !== {4'b1000, 32'd11}) begin
            miscompares++;
            $display("FAIL trunc restart: got %h want %h", obs, {4'b1000, 32'd11});
        end
        put(1'b1, 32'd0, 32'd0, 1'b1);
        cyc();
        vectors++;
        if (obs !== {4'b1100, 32'd0}) begin
            miscompares++;
            $display("FAIL trunc close: got %h want %h", obs, {4'b1100, 32'd0});
        end
        put(1'b0, '0, '0, 1'b0);
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        put(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        cyc();
        put(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL midreset outputs: got %h want 0", obs);
        end
        put(1'b1, 32'd5, 32'd6, 1'b1);
        cyc();
        vectors++;
        if (obs !== {4'b1100, 32'd11}) begin
            miscompares++;
            $display("FAIL midreset 5+6: got %h want %h", obs, {4'b1100, 32'd11});
        end
        put(1'b0, '0, '0, 1'b0);
        cyc();
    endtask

`ifdef WIDE_ADD_SEQ_SUB_EN
    task automatic test_sub();
        bus.out_ready = 1'b1;
        sub_drv = 1'b1;
        put(1'b1, 32'd43, 32'd45, 1'b1);
        cyc();
        vectors++;
        if (obs !== {4'b1100, 32'hFFFF_FFFE}) begin
            miscompares++;
            $display("FAIL sub 43-45: got %h want %h", obs, {4'b1100, 32'hFFFF_FFFE});
        end
        put(1'b1, 32'd45, 32'd43, 1'b1);
        cyc();
        vectors++;
        if (obs !== {4'b1110, 32'd2}) begin
            miscompares++;
            $display("FAIL sub 45-43: got %h want %h", obs, {4'b1110, 32'd2});
        end
        sub_drv = 1'b0;
        put(1'b0, '0, '0, 1'b0);
        cyc();
    endtask
`endif

    task automatic test_random();
        int idx = 0;
        int ncyc = 0;
        stim_q.delete();
        exp_q.delete();
        for (int op = 0; op < 120; op++) begin
            int len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                in_t w;
                w.a    = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
                w.b    = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
                w.last = (k == len - 1);
`ifdef WIDE_ADD_SEQ_SUB_EN
                w.sub  = $urandom_range(0, 1);
`else
                w.sub  = 1'b0;
`endif
                stim_q.push_back(w);
            end
        end
        build_expected();
        while ((idx < stim_q.size() || exp_q.size() > 0) && ncyc < 4000) begin
            logic pop, acc;
            bus.out_ready = ($urandom % 3 != 0);
            if (idx < stim_q.size() && $urandom % 4 != 0) begin
                put(1'b1, stim_q[idx].a, stim_q[idx].b, stim_q[idx].last);
`ifdef WIDE_ADD_SEQ_SUB_EN
                sub_drv = stim_q[idx].sub;
`endif
            end else begin
                put(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            #1;
            pop = bus.out_valid && bus.out_ready;
            acc = bus.in_valid && bus.in_ready;
            if (pop) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL random extra word: got %h want none", bus.out_sum);
                end else begin
                    exp_t e = exp_q.pop_front();
                    if (bus.out_sum !== e.sum || bus.out_last !== e.last ||
                        (e.last && (bus.out_carry !== e.carry || bus.out_err !== e.err))) begin
                        miscompares++;
                        $display("FAIL random word: got sum %h last %b carry %b err %b want sum %h last %b carry %b err %b",
                                 bus.out_sum, bus.out_last, bus.out_carry, bus.out_err,
                                 e.sum, e.last, e.carry, e.err);
                    end
                end
            end
            if (acc) idx++;
            cyc();
            ncyc++;
        end
        vectors++;
        if (idx != stim_q.size() || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random timeout: got %0d words sent %0d pending want %0d sent 0 pending",
                     idx, exp_q.size(), stim_q.size());
        end
        put(1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_truncation();
        test_reset_mid();
`ifdef WIDE_ADD_SEQ_SUB_EN
        test_sub();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
